// File: rtl/rca_pkg.sv
// rtl/rca_pkg.sv - shared helpers for the pipelined ripple adder/subtractor
package rca_pkg;

    // Bits handled by each pipeline stage.
    function automatic int seg_width(input int n, input int stages);
        return (stages >= 1) ? (n / stages) : n;
    endfunction

    // Legal configuration: at least one stage and a width that splits evenly.
    function automatic bit seg_cfg_ok(input int n, input int stages);
        return (stages >= 1) ? ((n % stages) == 0) : 1'b0;
    endfunction

endpackage

// File: rtl/rca_Nbit.sv
// rtl/rca_Nbit.sv - combinational N-bit ripple-carry adder
module rca_Nbit #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    logic carry;

    // Ripple the carry bit by bit from LSB to MSB.
    always_comb begin
        s     = '0;
        carry = cin;
        for (int i = 0; i < N; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/rca_pipe_stage.sv
// rtl/rca_pipe_stage.sv - one pipeline stage: adds segment IDX and registers the result
import rca_pkg::*;

module rca_pipe_stage #(
    parameter int N   = 32,
    parameter int SEG = 8,
    parameter int IDX = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_in,
    input  logic         rdy_next,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    input  logic [N-1:0] s_in,
    input  logic         c_in,
    output logic         valid_out,
    output logic [N-1:0] a_out,
    output logic [N-1:0] b_out,
    output logic [N-1:0] s_out,
    output logic         c_out
);

    localparam int LSB = IDX * SEG;

    logic [SEG-1:0] seg_sum;
    logic           seg_cout;
    logic [N-1:0]   s_next;
    logic           load;

    rca_Nbit #(.N(SEG)) u_seg_add (
        .a    (a_in[LSB +: SEG]),
        .b    (b_in[LSB +: SEG]),
        .cin  (c_in),
        .s    (seg_sum),
        .cout (seg_cout)
    );

    // An empty stage, or one whose content moves on this edge, can take new data.
    assign load = !valid_out || rdy_next;

    // Merge this stage's segment into the partial sum carried down the pipe.
    always_comb begin
        s_next              = s_in;
        s_next[LSB +: SEG]  = seg_sum;
    end

    // Stage register: valid bit always follows upstream on load, data only when valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            a_out     <= '0;
            b_out     <= '0;
            s_out     <= '0;
            c_out     <= 1'b0;
        end else if (load) begin
            valid_out <= valid_in;
            if (valid_in) begin
                a_out <= a_in;
                b_out <= b_in;
                s_out <= s_next;
                c_out <= seg_cout;
            end
        end
    end

endmodule

// File: rtl/rca_pipe_nbit.sv
// rtl/rca_pipe_nbit.sv - pipelined N-bit adder/subtractor with valid/ready handshake
import rca_pkg::*;

module rca_pipe_nbit #(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         ovf
);

    localparam int SEG = seg_width(N, STAGES);

    if (!seg_cfg_ok(N, STAGES)) begin : g_cfg_check
        $error("rca_pipe_nbit: N must be a multiple of STAGES and STAGES >= 1");
    end

    // Index k is the input of stage k; index STAGES is the last stage's register.
    logic [STAGES:0] vld;
    logic [STAGES:0] cy;
    logic [N-1:0]    a_p [0:STAGES];
    logic [N-1:0]    b_p [0:STAGES];
    logic [N-1:0]    s_p [0:STAGES];
    logic            rdy [0:STAGES];
    logic            unused_tail;

    assign vld[0] = in_valid;
    assign a_p[0] = a;
    assign b_p[0] = sub ? ~b : b;
    assign s_p[0] = '0;
    assign cy[0]  = sub ? 1'b1 : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        rca_pipe_stage #(
            .N   (N),
            .SEG (SEG),
            .IDX (k)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .valid_in  (vld[k]),
            .rdy_next  (rdy[k+1]),
            .a_in      (a_p[k]),
            .b_in      (b_p[k]),
            .s_in      (s_p[k]),
            .c_in      (cy[k]),
            .valid_out (vld[k+1]),
            .a_out     (a_p[k+1]),
            .b_out     (b_p[k+1]),
            .s_out     (s_p[k+1]),
            .c_out     (cy[k+1])
        );
    end

    // Ready chain from the consumer back to the input: a stage is free if empty or draining.
    always_comb begin
        rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = !vld[k+1] || rdy[k+1];
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld[STAGES];
    assign s         = s_p[STAGES];
    assign cout      = cy[STAGES];

    // Carry into the MSB recovered from the sum bit, compared with the carry out of it.
    assign ovf = (a_p[STAGES][N-1] ^ b_p[STAGES][N-1] ^ s_p[STAGES][N-1]) ^ cy[STAGES];

    // Only the MSBs of the final operand copies are needed downstream.
    assign unused_tail = ^{a_p[STAGES], b_p[STAGES]};

endmodule

// File: tb/tb_rca_pipe_nbit.sv
// tb/tb_rca_pipe_nbit.sv - self-checking bench for rca_pipe_nbit (N=32, STAGES=4)
module tb_rca_pipe_nbit;

    localparam int N  = 32;
    localparam int ST = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] s;
    logic         cout;
    logic         ovf;

    always #5 clk = ~clk;

    rca_pipe_nbit #(.N(N), .STAGES(ST)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] es;
        logic        ec;
        logic        eo;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    vec_t        tbl [9];
    vec_t        txq [$];
    logic [33:0] exp_q [$];
    int          got;
    int          accepted;
    int          stall_cycles;
    int          cyc_no;
    int          first_out;
    int          last_out;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference: plain 33-bit arithmetic, overflow from operand/result signs.
    function automatic logic [33:0] model(input vec_t v);
        logic [32:0] t;
        logic [31:0] yy;
        logic        c;
        logic        o;
        yy = v.sub ? ~v.b : v.b;
        c  = v.sub ? 1'b1 : v.cin;
        t  = {1'b0, v.a} + {1'b0, yy} + {32'b0, c};
        if (v.sub) o = (v.a[31] != v.b[31]) && (t[31] != v.a[31]);
        else       o = (v.a[31] == v.b[31]) && (t[31] != v.a[31]);
        return {t[32], o, t[31:0]};
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        v.a   = $urandom;
        v.b   = $urandom;
        v.cin = 1'($urandom_range(0, 1));
        v.sub = 1'($urandom_range(0, 1));
        v.es  = '0;
        v.ec  = 1'b0;
        v.eo  = 1'b0;
        return v;
    endfunction

    // Cycle-by-cycle driver/monitor; entered and left at posedge+1.
    task automatic run_cycles(input int ncyc, input logic ordy, input int max_got);
        logic [33:0] e;
        for (int c = 0; c < ncyc && got < max_got; c++) begin
            out_ready = ordy;
            if (txq.size() > 0) begin
                a = txq[0].a; b = txq[0].b; cin = txq[0].cin; sub = txq[0].sub;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !ordy && exp_q.size() > 0) begin
                e = exp_q[0];
                check("stall_hold_s", 64'(s), 64'(e[31:0]));
            end
            if (out_valid && ordy) begin
                if (exp_q.size() == 0) begin
                    check("spurious_result", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("stream_result", 64'({cout, ovf, s}), 64'(e));
                end
                if (first_out < 0) first_out = cyc_no;
                last_out = cyc_no;
                got++;
            end
            if (in_valid && !in_ready) stall_cycles++;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(txq[0]));
                void'(txq.pop_front());
                accepted++;
            end
            @(posedge clk); #1;
            cyc_no++;
        end
        in_valid = 1'b0;
    endtask

    task automatic phase_reset();
        got = 0; accepted = 0; stall_cycles = 0; first_out = -1; last_out = -1;
    endtask

    initial begin
        int edges;
        int seen;
        logic [33:0] e;

        tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
        tbl[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        tbl[2] = '{32'h00000003, 32'h00000004, 1'b1, 1'b0, 32'h00000008, 1'b0, 1'b0};
        tbl[3] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        tbl[4] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        tbl[5] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
        tbl[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
        tbl[7] = '{32'h12345678, 32'h0000FFFF, 1'b1, 1'b0, 32'h12355678, 1'b0, 1'b0};
        tbl[8] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};

        cyc_no = 0;
        phase_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_s", 64'(s), 64'(0));
        check("reset_cout_ovf", 64'({cout, ovf}), 64'(0));
        check("reset_in_ready", 64'(in_ready), 64'(1));

        // Directed single transactions: latency and arithmetic
        for (int i = 0; i < 9; i++) begin
            a = tbl[i].a; b = tbl[i].b; cin = tbl[i].cin; sub = tbl[i].sub;
            out_ready = 1'b1;
            in_valid  = 1'b1;
            #1;
            check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(1));
            @(posedge clk); #1;
            in_valid = 1'b0;
            edges = 1;
            while (!out_valid && edges < 12) begin
                @(posedge clk); #1;
                edges++;
            end
            check($sformatf("vec%0d_latency", i), 64'(edges), 64'(ST));
            check($sformatf("vec%0d_s", i), 64'(s), 64'(tbl[i].es));
            check($sformatf("vec%0d_cout", i), 64'(cout), 64'(tbl[i].ec));
            check($sformatf("vec%0d_ovf", i), 64'(ovf), 64'(tbl[i].eo));
            @(posedge clk); #1;
            check($sformatf("vec%0d_drained", i), 64'(out_valid), 64'(0));
        end

        // Streaming: 8 back-to-back with out_ready held high
        phase_reset();
        exp_q.delete();
        for (int i = 0; i < 8; i++) txq.push_back(rand_vec());
        run_cycles(30, 1'b1, 8);
        check("stream_count", 64'(got), 64'(8));
        check("stream_contiguous", 64'(last_out - first_out), 64'(7));
        check("stream_no_stall", 64'(stall_cycles), 64'(0));

        // Backpressure: 6 offered while out_ready=0, then drain
        phase_reset();
        exp_q.delete();
        for (int i = 0; i < 6; i++) txq.push_back(rand_vec());
        run_cycles(6, 1'b0, 99);
        check("bp_accepted", 64'(accepted), 64'(4));
        check("bp_stall_cycles", 64'(stall_cycles), 64'(2));
        out_ready = 1'b0;
        in_valid  = 1'b1;
        #1;
        check("bp_in_ready_low", 64'(in_ready), 64'(0));
        check("bp_out_valid", 64'(out_valid), 64'(1));
        in_valid = 1'b0;
        phase_reset();
        run_cycles(20, 1'b1, 6);
        check("bp_drain_count", 64'(got), 64'(6));
        check("bp_drain_contiguous", 64'(last_out - first_out), 64'(5));
        check("bp_queue_empty", 64'(exp_q.size()), 64'(0));

        // Reset with 3 transactions in flight
        phase_reset();
        exp_q.delete();
        txq.push_back('{32'h11111111, 32'h22222222, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0});
        txq.push_back('{32'hF0000000, 32'h20000000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0});
        txq.push_back('{32'h00000009, 32'h00000002, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0});
        run_cycles(3, 1'b1, 99);
        check("rst_pre_accepted", 64'(accepted), 64'(3));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_s", 64'(s), 64'(0));
        check("rst_cout_ovf", 64'({cout, ovf}), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("rst_no_stale", 64'(seen), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
